// File: rtl/fe_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle imem interface,
// DEPTH-entry {pc,isn} queue with valid/ready output, redirect and halt support.
// Optional performance counters are enabled by defining FE_PERF_CNT_EN.
module fe_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fe_halt,
  input  logic            de_ready,
  output logic            fe_valid,
  output logic [XLEN-1:0] fe_pc,
  output logic [ILEN-1:0] fe_isn
`ifdef FE_PERF_CNT_EN
  ,
  output logic [31:0]     fe_stall_cnt,
  output logic [31:0]     fe_empty_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   pc_mem_q  [DEPTH];
  logic [ILEN-1:0]   isn_mem_q [DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occ;

  // Next-state, issue, handshake and queue pointer logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    addr_d     = addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    imem_req   = 1'b0;
    fe_valid   = 1'b0;
    occ        = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_FLUSH: begin
        state_d = ST_RUN;
        issue   = ~fe_halt & ~redirect_valid & (occ < (CNT_W+1)'(DEPTH));
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    fe_valid = (count_q != '0) & ~redirect_valid;
    pop      = fe_valid & de_ready;
    // The response landing in FLUSH belongs to the discarded path
    push     = inflight_q & (state_q != ST_FLUSH);

    if (issue) begin
      imem_req   = 1'b1;
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      inflight_d = 1'b1;
      addr_d     = fetch_pc_q;
    end

    if (redirect_valid) begin
      // Redirect clears the queue and drops the response arriving this cycle
      fetch_pc_d = redirect_pc;
      state_d    = inflight_q ? ST_FLUSH : ST_RUN;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      push       = 1'b0;
    end else begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage, written at the tail on each accepted response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]  <= '0;
        isn_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]  <= addr_q;
      isn_mem_q[tail_q] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign fe_pc     = pc_mem_q[head_q];
  assign fe_isn    = isn_mem_q[head_q];

`ifdef FE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] empty_cnt_q;

  // Saturating stall / empty cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else begin
      if (fe_valid && !de_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((state_q == ST_RUN) && (count_q == '0) && !redirect_valid &&
          (empty_cnt_q != 32'hFFFF_FFFF)) begin
        empty_cnt_q <= empty_cnt_q + 32'd1;
      end
    end
  end

  assign fe_stall_cnt = stall_cnt_q;
  assign fe_empty_cnt = empty_cnt_q;
`endif

endmodule

// File: tb/tb_fe_fetch_queue.sv
// Directed bench for fe_fetch_queue: startup latency, backpressure, redirect,
// halt, PC wrap (second instance with a high RESET_PC) and mid-cycle reset.
module tb_fe_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, b_req;
  logic [31:0] imem_addr, b_addr;
  logic [31:0] imem_rdata, b_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fe_halt;
  logic        de_ready;
  logic        fe_valid, b_valid;
  logic [31:0] fe_pc, b_pc;
  logic [31:0] fe_isn, b_isn;
`ifdef FE_PERF_CNT_EN
  logic [31:0] fe_stall_cnt, fe_empty_cnt, b_stall_cnt, b_empty_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] isn_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Instruction memory models, one-cycle read latency
  always @(posedge clk) imem_rdata <= isn_of(imem_addr);
  always @(posedge clk) b_rdata    <= isn_of(b_addr);

  fe_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fe_halt(fe_halt), .de_ready(de_ready),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_isn(fe_isn)
`ifdef FE_PERF_CNT_EN
    , .fe_stall_cnt(fe_stall_cnt), .fe_empty_cnt(fe_empty_cnt)
`endif
  );

  fe_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .fe_halt(1'b0), .de_ready(1'b1),
    .fe_valid(b_valid), .fe_pc(b_pc), .fe_isn(b_isn)
`ifdef FE_PERF_CNT_EN
    , .fe_stall_cnt(b_stall_cnt), .fe_empty_cnt(b_empty_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  // Hold reset two edges, release between edges; cycle 0 is BOOT
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    cyc_n = 0;
  endtask

  // Advance to cycle k (1 time unit after its opening edge)
  task automatic go(input int k);
    while (cyc_n < k) begin
      @(posedge clk);
      #1;
      cyc_n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fe_halt = 1'b0;
    de_ready = 1'b1;
    #12;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(fe_valid), 32'd0);
    chk("rst_pc",    fe_pc,         32'd0);
    chk("rst_isn",   fe_isn,        32'd0);

    // Startup latency and sequential PCs; instance B wraps past 2^32
    do_reset();
    #1;
    chk("t1_boot_req", 32'(imem_req), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      go(k);
      #1;
      if (k < 3) begin
        chk("t1_valid_lo", 32'(fe_valid), 32'd0);
      end else begin
        chk("t1_valid", 32'(fe_valid), 32'd1);
        chk("t1_pc",    fe_pc,  32'(4 * (k - 3)));
        chk("t1_isn",   fe_isn, isn_of(32'(4 * (k - 3))));
        chk("t5_valid", 32'(b_valid), 32'd1);
        chk("t5_pc",    b_pc,  32'hFFFF_FFF8 + 32'(4 * (k - 3)));
        chk("t5_isn",   b_isn, isn_of(32'hFFFF_FFF8 + 32'(4 * (k - 3))));
      end
    end

    // Backpressure: exactly four requests, then drain in order
    de_ready = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      go(k);
      #1;
      chk("t2_req", 32'(imem_req), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) chk("t2_addr", imem_addr, 32'(4 * (k - 1)));
    end
    for (int k = 11; k <= 15; k++) begin
      go(k);
      de_ready = 1'b1;
      #1;
      chk("t2_valid", 32'(fe_valid), 32'd1);
      chk("t2_pc", fe_pc, 32'(4 * (k - 11)));
      if (k == 11) chk("t2_full_req", 32'(imem_req), 32'd0);
      if (k == 12) begin
        chk("t2_next_req",  32'(imem_req), 32'd1);
        chk("t2_next_addr", imem_addr,     32'h10);
      end
    end

    // Redirect with three queued entries and a response in flight
    de_ready = 1'b0;
    do_reset();
    go(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    de_ready = 1'b1;
    #1;
    chk("t3_valid_t", 32'(fe_valid), 32'd0);
    chk("t3_req_t",   32'(imem_req), 32'd0);
    go(6);
    redirect_valid = 1'b0;
    #1;
    chk("t3_valid_t1", 32'(fe_valid), 32'd0);
    chk("t3_req_t1",   32'(imem_req), 32'd1);
    chk("t3_addr_t1",  imem_addr,     32'h100);
    go(7);
    #1;
    chk("t3_valid_t2", 32'(fe_valid), 32'd0);
    go(8);
    #1;
    chk("t3_valid_t3", 32'(fe_valid), 32'd1);
    chk("t3_pc0",  fe_pc,  32'h100);
    chk("t3_isn0", fe_isn, isn_of(32'h100));
    go(9);
    #1;
    chk("t3_pc1", fe_pc, 32'h104);

    // Halt for five cycles: no requests, queue drains, PCs resume without gap
    de_ready = 1'b1;
    do_reset();
    go(6);
    fe_halt = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      go(k);
      #1;
      chk("t4_req", 32'(imem_req), 32'd0);
      if (k == 6) chk("t4_pc6", fe_pc, 32'hC);
      if (k == 7) chk("t4_pc7", fe_pc, 32'h10);
      if (k >= 8) chk("t4_empty", 32'(fe_valid), 32'd0);
    end
    go(11);
    fe_halt = 1'b0;
    #1;
    chk("t4_resume_req",  32'(imem_req), 32'd1);
    chk("t4_resume_addr", imem_addr,     32'h14);
    go(13);
    #1;
    chk("t4_resume_valid", 32'(fe_valid), 32'd1);
    chk("t4_resume_pc",    fe_pc,         32'h14);

    // Full queue, then asynchronous reset mid-cycle
    de_ready = 1'b0;
    do_reset();
    go(13);
    #1;
    chk("t6_full_valid", 32'(fe_valid), 32'd1);
    chk("t6_full_req",   32'(imem_req), 32'd0);
`ifdef FE_PERF_CNT_EN
    chk("t6_stall_cnt", fe_stall_cnt, 32'd10);
    chk("t6_empty_cnt", fe_empty_cnt, 32'd2);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(fe_valid), 32'd0);
    chk("t6_rst_req",   32'(imem_req), 32'd0);
    de_ready = 1'b1;
    do_reset();
    go(1);
    #1;
    chk("t6_restart_addr", imem_addr, 32'h0);
    go(3);
    #1;
    chk("t6_restart_valid", 32'(fe_valid), 32'd1);
    chk("t6_restart_pc",    fe_pc,         32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
